iter_alu: RTL and testbench

//  Parametrised sequential ALU for the multi-cycle CPU datapath. Executes the

---
 rtl/iter_alu.sv | 221 ++++++++++++++++++++++
 tb/tb_iter_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Sequential ALU: single-cycle base ops plus iterative unsigned multiply/divide
// (one bit per cycle) behind a start/busy/done handshake. All outputs registered.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUopcode,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             sign,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_NOR  = 4'b1010,
        OP_MULU = 4'b1011,
        OP_DIVU = 4'b1100
    } op_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] add_res, sub_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign add_res = rega + regb;
    assign sub_res = rega - regb;
    assign shamt   = rega[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUopcode)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (rega[WIDTH-1] == regb[WIDTH-1]) && (add_res[WIDTH-1] != rega[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (rega[WIDTH-1] != regb[WIDTH-1]) && (sub_res[WIDTH-1] != rega[WIDTH-1]);
            end
            OP_SLL:  alu_res = regb << shamt;
            OP_OR:   alu_res = rega | regb;
            OP_AND:  alu_res = rega & regb;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rega < regb)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
            OP_SRL:  alu_res = regb >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(regb) >>> shamt);
            OP_XOR:  alu_res = rega ^ regb;
            OP_NOR:  alu_res = ~(rega | regb);
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // MULU: {hi,lo} starts as {0,B}; conditional add of A into hi, then shift right.
    // DIVU: lo starts as A and collects quotient bits; hi is the partial remainder.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, a_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ALUopcode == OP_MULU) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        div_d   = 1'b0;
                        a_d     = rega;
                        hi_d    = '0;
                        lo_d    = regb;
                    end else if (ALUopcode == OP_DIVU) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        div_d   = 1'b1;
                        a_d     = regb;
                        hi_d    = '0;
                        lo_d    = rega;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        res_d    = alu_res;
                        res_hi_d = '0;
                        ovf_d    = alu_ovf;
                    end
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    res_d    = step_lo;
                    res_hi_d = step_hi;
                    ovf_d    = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        zero_d = zero_q;
        sign_d = sign_q;
        if (done_d) begin
            zero_d = (res_d == '0);
            sign_d = res_d[WIDTH-1];
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomized self-checking bench for iter_alu against an arithmetic reference model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ALUopcode = '0;
    logic [31:0] rega = '0;
    logic [31:0] regb = '0;
    logic        busy, done, zero, sign, ovf;
    logic [31:0] result, result_hi;

    int checks = 0;
    int errors = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    iter_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ALUopcode (ALUopcode),
        .rega      (rega),
        .regb      (regb),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .sign      (sign),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] rh, output logic v);
        longint          sa, sb, s;
        longint unsigned p;
        logic [63:0]     pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        rh = '0;
        v  = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; pv = s; r = pv[31:0]; v = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = sa - sb; pv = s; r = pv[31:0]; v = (s > SMAX) || (s < SMIN); end
            4'd2:  r = b << a[4:0];
            4'd3:  r = a | b;
            4'd4:  r = a & b;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  r = b >> a[4:0];
            4'd8:  r = $unsigned($signed(b) >>> a[4:0]);
            4'd9:  r = a ^ b;
            4'd10: r = ~(a | b);
            4'd11: begin
                p  = longint'(a) * longint'(b);
                pv = p;
                r  = pv[31:0];
                rh = pv[63:32];
            end
            4'd12: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; rh = a; end
                else begin r = a / b; rh = a % b; end
            end
            default: r = '0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3, 0) == 0) return corners[$urandom_range(4, 0)];
        return $urandom;
    endfunction

    // inj: cycle at which a stray ADD start is pulsed while busy (0 = none)
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [31:0] er, erh, prev_r, prev_h;
        logic        ev;
        int          lat, exp_lat;
        bit          busy_ok, stable;
        model(op, a, b, er, erh, ev);
        exp_lat = (op == 4'd11 || op == 4'd12) ? 33 : 1;
        @(negedge clk);
        prev_r = result;
        prev_h = result_hi;
        start = 1'b1; ALUopcode = op; rega = a; regb = b;
        @(negedge clk);
        start = 1'b0; ALUopcode = 4'($urandom); rega = $urandom; regb = $urandom;
        lat = 0; busy_ok = 1'b1; stable = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin lat = c; break; end
            if (!busy) busy_ok = 1'b0;
            if (result !== prev_r || result_hi !== prev_h) stable = 1'b0;
            if (c == inj) begin
                start = 1'b1; ALUopcode = 4'd0; rega = $urandom; regb = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
        check($sformatf("result op%0d a=%0h b=%0h", op, a, b), 64'(result), 64'(er));
        check($sformatf("result_hi op%0d", op), 64'(result_hi), 64'(erh));
        check($sformatf("zero op%0d", op), 64'(zero), 64'(er == 0));
        check($sformatf("sign op%0d", op), 64'(sign), 64'(er[31]));
        check($sformatf("ovf op%0d", op), 64'(ovf), 64'(ev));
        check("busy_at_done", 64'(busy), 64'd1);
        if (exp_lat > 1) begin
            check("busy_during_calc", 64'(busy_ok), 64'd1);
            check("outputs_stable_calc", 64'(stable), 64'd1);
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("result_hold", 64'(result), 64'(er));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, done, result, result_hi, zero, sign, ovf}, 64'd0);
    endtask

    task automatic reset_mid_divu();
        @(negedge clk);
        start = 1'b1; ALUopcode = 4'd12; rega = 32'hDEAD_BEEF; regb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_outputs");
        repeat (3) @(negedge clk);
        check("no_done_in_reset", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_done_after_reset", 64'(done), 64'd0);
        run_op(4'd0, 32'd2, 32'd3, 0);
        check("add_after_reset", 64'(result), 64'd5);
    endtask

    initial begin
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
        check("add_ovf_result", 64'(result), 64'h8000_0000);
        run_op(4'd6, 32'hFFFF_FFFF, 32'h1, 0);
        check("slt_neg", 64'(result), 64'd1);
        run_op(4'd5, 32'hFFFF_FFFF, 32'h1, 0);
        check("sltu_big", 64'(result), 64'd0);
        run_op(4'd8, 32'd4, 32'h8000_0000, 0);
        check("sra", 64'(result), 64'hF800_0000);
        run_op(4'd11, 32'hFFFF_FFFF, 32'd2, 0);
        check("mulu_hi", 64'(result_hi), 64'd1);
        run_op(4'd12, 32'd100, 32'd7, 0);
        check("divu_q", 64'(result), 64'd14);
        run_op(4'd12, 32'd5, 32'd0, 0);
        check("divu0_rem", 64'(result_hi), 64'd5);
        run_op(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        run_op(4'd13, 32'h1, 32'h2, 0);
        run_op(4'd1, 32'h8000_0000, 32'h1, 0);

        reset_mid_divu();

        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(15, 0));
            a  = pick();
            b  = pick();
            run_op(op, a, b, (i % 7 == 0) ? 3 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
